// File: rtl/ifetch_ifid_stage_if.sv
// ifetch_ifid_stage_if: instruction memory bus between the fetch stage and a 256x32 combinational imem.
//   imem_addr  8-bit word address driven by the fetch stage (master)
//   imem_inst  32-bit read data returned in the same cycle (slave)
interface ifetch_ifid_stage_if;
    logic [7:0]  imem_addr;
    logic [31:0] imem_inst;
    modport master (output imem_addr, input imem_inst);
    modport slave  (input imem_addr, output imem_inst);
endinterface

// File: rtl/ifetch_ifid_stage.sv
// ifetch_ifid_stage: fetch PC plus IF/ID pipeline register with stall, flush and redirect.
//   clk, rst_n          clock, asynchronous active-low reset
//   stall_i, flush_i    decode-side hold / bubble request
//   redirect_i/_pc_i    branch/jump target load (inserts one bubble)
//   imem                master side of the instruction memory bus (addr = pc_o[7:0])
//   pc_o                current fetch PC
//   ifid_pc/inst/valid  IF/ID register contents (valid=0 marks a bubble)
//   stall_cnt_o, flush_cnt_o  saturating event counters, present only with IFETCH_PERF_EN
module ifetch_ifid_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] NOP_INST = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic                    redirect_i,
    input  logic [31:0]             redirect_pc_i,
    ifetch_ifid_stage_if.master     imem,
    output logic [31:0]             pc_o,
    output logic [31:0]             ifid_pc_o,
    output logic [31:0]             ifid_inst_o,
`ifdef IFETCH_PERF_EN
    output logic [31:0]             stall_cnt_o,
    output logic [31:0]             flush_cnt_o,
`endif
    output logic                    ifid_valid_o
);
    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d, run, adv, bubble;
    always_comb begin
        run          = state_q != BOOT;
        adv          = run && !redirect_i && !stall_i;
        // Full bubble (pc 0): redirect anywhere, or flush while stalled.
        // Flush during a normal advance keeps the advancing pc.
        bubble       = redirect_i || (run && flush_i);
        pc_d         = redirect_i ? redirect_pc_i : adv ? pc_q + PC_STEP : pc_q;
        ifid_pc_d    = adv ? pc_q : bubble ? 32'd0 : ifid_pc_q;
        ifid_inst_d  = adv ? (flush_i ? NOP_INST : imem.imem_inst) : bubble ? NOP_INST : ifid_inst_q;
        ifid_valid_d = adv ? !flush_i : bubble ? 1'b0 : ifid_valid_q;
        state_d      = (run && stall_i) ? HOLD : RUN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end
`ifdef IFETCH_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (run && stall_i && !redirect_i && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bubble && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif
    assign imem.imem_addr = pc_q[7:0];
    assign pc_o           = pc_q;
    assign ifid_pc_o      = ifid_pc_q;
    assign ifid_inst_o    = ifid_inst_q;
    assign ifid_valid_o   = ifid_valid_q;
endmodule

// File: tb/tb_ifetch_ifid_stage.sv
// tb_ifetch_ifid_stage: directed checks of fetch/IF-ID sequencing with imem[k]=32'h5000_0000+k.
module tb_ifetch_ifid_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic [31:0] pc_o, ifid_pc_o, ifid_inst_o;
    logic        ifid_valid_o;
`ifdef IFETCH_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif
    int          n_run = 0;
    int          n_fail = 0;

    ifetch_ifid_stage_if mif ();
    assign mif.imem_inst = 32'h5000_0000 + {24'd0, mif.imem_addr};

    ifetch_ifid_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .imem(mif),
        .pc_o(pc_o), .ifid_pc_o(ifid_pc_o), .ifid_inst_o(ifid_inst_o),
`ifdef IFETCH_PERF_EN
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
        .ifid_valid_o(ifid_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic v);
        check({tag, "_ifid_pc"}, ifid_pc_o, pc);
        check({tag, "_ifid_inst"}, ifid_inst_o, inst);
        check({tag, "_valid"}, {31'd0, ifid_valid_o}, {31'd0, v});
    endtask

    initial begin
        #2;
        check("rst_pc", pc_o, 32'd0);
        check("rst_addr", {24'd0, mif.imem_addr}, 32'd0);
        ifid("rst", 32'd0, 32'd0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check("boot_pc", pc_o, 32'd0);
        check("boot_valid", {31'd0, ifid_valid_o}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            ifid("seq", k, 32'h5000_0000 + k, 1'b1);
            check("seq_pc", pc_o, k + 1);
        end
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_pc", pc_o, 32'd5);
            ifid("stall", 32'd4, 32'h5000_0004, 1'b1);
        end
        stall_i = 1'b0;
        step();
        ifid("unstall", 32'd5, 32'h5000_0005, 1'b1);
        check("unstall_pc", pc_o, 32'd6);
        redirect_i = 1'b1;
        redirect_pc_i = 32'd200;
        stall_i = 1'b1;
        step();
        redirect_i = 1'b0;
        stall_i = 1'b0;
        check("redir_pc", pc_o, 32'd200);
        ifid("redir", 32'd0, 32'd0, 1'b0);
        step();
        ifid("redir_fetch", 32'd200, 32'h5000_00C8, 1'b1);
        check("redir_next_pc", pc_o, 32'd201);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        ifid("flush", 32'd201, 32'd0, 1'b0);
        check("flush_pc", pc_o, 32'd202);
        step();
        ifid("post_flush", 32'd202, 32'h5000_00CA, 1'b1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'd254;
        step();
        redirect_i = 1'b0;
        check("wrap_addr0", {24'd0, mif.imem_addr}, 32'd254);
        step();
        check("wrap_addr1", {24'd0, mif.imem_addr}, 32'd255);
        step();
        check("wrap_addr2", {24'd0, mif.imem_addr}, 32'd0);
        check("wrap_pc", pc_o, 32'd256);
        step();
        ifid("wrap", 32'd256, 32'h5000_0000, 1'b1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'd36;
        step();
        redirect_i = 1'b0;
        step();
        stall_i = 1'b1;
        step();
        check("pre_rst_pc", pc_o, 32'd37);
`ifdef IFETCH_PERF_EN
        check("stall_cnt", stall_cnt_o, 32'd4);
        check("flush_cnt", flush_cnt_o, 32'd4);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", pc_o, 32'd0);
        ifid("async", 32'd0, 32'd0, 1'b0);
`ifdef IFETCH_PERF_EN
        check("async_stall_cnt", stall_cnt_o, 32'd0);
        check("async_flush_cnt", flush_cnt_o, 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
